// File: rtl/flexcounter_pkg.sv
// Shared types and defaults for the multi-channel flex counter.
// Mode encoding is fixed because firmware writes it directly into the mode field.
package flexcounter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_DOWN    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    localparam int DEF_COUNTSIZE = 1024;

endpackage

// File: rtl/flexcounter_chan.sv
// One flex counter channel: wrap, one-shot or down-reload counting with a
// combinational terminal event (used for cascading) and a registered strobe.
module flexcounter_chan
    import flexcounter_pkg::*;
#(
    parameter int COUNTWIDTH = 10
) (
    input  logic                  clk,
    input  logic                  nRST,
    input  logic                  adv,
    input  logic                  clear,
    input  mode_t                 mode,
    input  logic [COUNTWIDTH-1:0] maxCount,
    output logic [COUNTWIDTH-1:0] count,
    output logic                  term,
    output logic                  strobe,
    output logic                  done
);

    localparam logic [COUNTWIDTH-1:0] ONE = COUNTWIDTH'(1);

    logic [COUNTWIDTH-1:0] next_count;
    logic                  next_done;

    always_comb begin
        term       = 1'b0;
        next_count = count;
        next_done  = done;
        if (clear) begin
            next_count = (mode == MODE_DOWN) ? maxCount : '0;
            next_done  = 1'b0;
        end else if (adv) begin
            case (mode)
                MODE_ONESHOT: begin
                    if (!done) begin
                        if (count >= maxCount) begin
                            term       = 1'b1;
                            next_count = maxCount;
                            next_done  = 1'b1;
                        end else begin
                            next_count = count + ONE;
                        end
                    end
                end
                MODE_DOWN: begin
                    if (count == '0) begin
                        term       = 1'b1;
                        next_count = maxCount;
                    end else begin
                        next_count = count - ONE;
                    end
                end
                default: begin
                    // >= rather than == so a lowered terminal value still wraps
                    if (count >= maxCount) begin
                        term       = 1'b1;
                        next_count = '0;
                    end else begin
                        next_count = count + ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            count  <= '0;
            done   <= 1'b0;
            strobe <= 1'b0;
        end else begin
            count  <= next_count;
            done   <= next_done;
            strobe <= term;
        end
    end

endmodule

// File: rtl/flexcounter_multi.sv
// NCHAN independent flex counters; channel i can advance on channel i-1's
// terminal event, so a cascade chain ripples within a single cycle.
module flexcounter_multi
    import flexcounter_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int COUNTSIZE  = DEF_COUNTSIZE,
    parameter int COUNTWIDTH = $clog2(COUNTSIZE)
) (
    input  logic                        clk,
    input  logic                        nRST,
    input  logic [NCHAN-1:0]            enableCounter,
    input  logic [NCHAN-1:0]            clear,
    input  logic [NCHAN-1:0]            cascade,
    input  logic [2*NCHAN-1:0]          mode,
    input  logic [NCHAN*COUNTWIDTH-1:0] maxCount,
    output logic [NCHAN-1:0]            strobe,
    output logic [NCHAN*COUNTWIDTH-1:0] count,
    output logic [NCHAN-1:0]            done
);

    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic adv_w;
        logic term_w;

        // Per-channel scalars keep the ripple chain free of false loops.
        if (i == 0) begin : g_first
            assign adv_w = enableCounter[0];
        end else begin : g_next
            assign adv_w = enableCounter[i] & (cascade[i] ? g_chan[i-1].term_w : 1'b1);
        end

        flexcounter_chan #(
            .COUNTWIDTH (COUNTWIDTH)
        ) u_chan (
            .clk      (clk),
            .nRST     (nRST),
            .adv      (adv_w),
            .clear    (clear[i]),
            .mode     (mode_t'(mode[2*i +: 2])),
            .maxCount (maxCount[i*COUNTWIDTH +: COUNTWIDTH]),
            .count    (count[i*COUNTWIDTH +: COUNTWIDTH]),
            .term     (term_w),
            .strobe   (strobe[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_flexcounter_multi.sv
// Directed and randomized checks of flexcounter_multi against a per-cycle
// behavioural model of the counting rules.
module tb_flexcounter_multi;

    localparam int NCHAN = 4;
    localparam int W     = 10;

    logic                 clk = 1'b0;
    logic                 nRST;
    logic [NCHAN-1:0]     enableCounter;
    logic [NCHAN-1:0]     clear;
    logic [NCHAN-1:0]     cascade;
    logic [2*NCHAN-1:0]   mode;
    logic [NCHAN*W-1:0]   maxCount;
    logic [NCHAN-1:0]     strobe;
    logic [NCHAN*W-1:0]   count;
    logic [NCHAN-1:0]     done;

    int errors = 0;
    int checks = 0;

    int m_cnt    [NCHAN];
    bit m_done   [NCHAN];
    bit m_stb    [NCHAN];
    int stb_seen [NCHAN];

    always #5 clk = ~clk;

    flexcounter_multi #(
        .NCHAN     (NCHAN),
        .COUNTSIZE (1024)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .enableCounter (enableCounter),
        .clear         (clear),
        .cascade       (cascade),
        .mode          (mode),
        .maxCount      (maxCount),
        .strobe        (strobe),
        .count         (count),
        .done          (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_cnt[i]  = 0;
            m_done[i] = 0;
            m_stb[i]  = 0;
        end
    endfunction

    // Evaluates channels in order so a terminal event feeds the next channel same cycle.
    function automatic void model_step();
        bit t_prev;
        bit a;
        bit t;
        int mx;
        int md;
        t_prev = 0;
        for (int i = 0; i < NCHAN; i++) begin
            mx = int'(maxCount[i*W +: W]);
            md = int'(mode[2*i +: 2]);
            a  = enableCounter[i] && (i == 0 || !cascade[i] || t_prev);
            t  = 0;
            if (clear[i]) begin
                m_cnt[i]  = (md == 2) ? mx : 0;
                m_done[i] = 0;
            end else if (a) begin
                if (md == 1) begin
                    if (!m_done[i]) begin
                        if (m_cnt[i] >= mx) begin
                            t = 1; m_cnt[i] = mx; m_done[i] = 1;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end
                end else if (md == 2) begin
                    if (m_cnt[i] == 0) begin
                        t = 1; m_cnt[i] = mx;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end else begin
                    if (m_cnt[i] >= mx) begin
                        t = 1; m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            m_stb[i] = t;
            t_prev   = t;
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NCHAN; i++) begin
            check($sformatf("count[%0d]", i), int'(count[i*W +: W]), m_cnt[i]);
            check($sformatf("strobe[%0d]", i), int'(strobe[i]), int'(m_stb[i]));
            check($sformatf("done[%0d]", i), int'(done[i]), int'(m_done[i]));
            if (strobe[i]) stb_seen[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_chan(input int i, input int md, input int mx);
        mode[2*i +: 2]     = 2'(md);
        maxCount[i*W +: W] = W'(mx);
    endtask

    // Called at posedge+1; asserts reset between edges and releases before the next edge.
    task automatic mid_reset();
        #3;
        nRST = 1'b0;
        #1;
        check("rst_count_zero", int'(count != '0), 0);
        check("rst_strobe_zero", int'(strobe), 0);
        check("rst_done_zero", int'(done), 0);
        model_reset();
        #2;
        nRST = 1'b1;
    endtask

    function automatic int cnt_of(input int i);
        return int'(count[i*W +: W]);
    endfunction

    initial begin
        nRST          = 1'b0;
        enableCounter = '0;
        clear         = '0;
        cascade       = '0;
        mode          = '0;
        maxCount      = '0;
        model_reset();
        for (int i = 0; i < NCHAN; i++) stb_seen[i] = 0;

        // 1: reset then WRAP on ch0 with maxCount=3
        #22;
        check("reset_strobe", int'(strobe), 0);
        check("reset_count", int'(count != '0), 0);
        check("reset_done", int'(done), 0);
        nRST = 1'b1;
        set_chan(0, 0, 3);
        enableCounter = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t1_count", cnt_of(0), k % 4);
            check("t1_strobe", int'(strobe[0]), (k % 4 == 0) ? 1 : 0);
        end

        // 2: ONESHOT on ch1 with maxCount=5
        enableCounter = '0;
        set_chan(1, 1, 5);
        clear = 4'b0010;
        step();
        clear = '0;
        enableCounter = 4'b0010;
        stb_seen[1] = 0;
        repeat (12) step();
        check("t2_count_hold", cnt_of(1), 5);
        check("t2_done", int'(done[1]), 1);
        check("t2_one_strobe", stb_seen[1], 1);
        clear = 4'b0010;
        step();
        check("t2_clear_count", cnt_of(1), 0);
        check("t2_clear_done", int'(done[1]), 0);
        clear = '0;
        step();
        check("t2_restart", cnt_of(1), 1);

        // 3: DOWN on ch2 from reset with maxCount=4
        enableCounter = '0;
        mid_reset();
        set_chan(2, 2, 4);
        enableCounter = 4'b0100;
        step();
        check("t3_first_reload", cnt_of(2), 4);
        check("t3_first_strobe", int'(strobe[2]), 1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t3_count", cnt_of(2), (k == 5) ? 4 : 4 - k);
            check("t3_strobe", int'(strobe[2]), (k == 5) ? 1 : 0);
        end
        clear = 4'b0100;
        step();
        check("t3_clear_load", cnt_of(2), 4);
        check("t3_clear_nostrobe", int'(strobe[2]), 0);
        clear = '0;

        // 4: BCD-style cascade of ch0 into ch1
        enableCounter = '0;
        set_chan(0, 0, 9);
        set_chan(1, 0, 9);
        cascade = 4'b0010;
        clear   = 4'b0011;
        step();
        clear = '0;
        enableCounter = 4'b0011;
        stb_seen[1] = 0;
        repeat (250) step();
        check("t4_ch1_count", cnt_of(1), 5);
        check("t4_ch0_count", cnt_of(0), 0);
        check("t4_ch1_strobes", stb_seen[1], 2);

        // 5: priority and boundaries on ch3
        enableCounter = '0;
        cascade = '0;
        set_chan(3, 0, 7);
        clear = 4'b1000;
        enableCounter = 4'b1000;
        step();
        check("t5_clear_wins", cnt_of(3), 0);
        check("t5_clear_nostrobe", int'(strobe[3]), 0);
        clear = '0;
        repeat (5) step();
        check("t5_at_five", cnt_of(3), 5);
        set_chan(3, 0, 2);
        step();
        check("t5_lowered_wrap", cnt_of(3), 0);
        check("t5_lowered_strobe", int'(strobe[3]), 1);
        set_chan(3, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_max0_strobe", int'(strobe[3]), 1);
            check("t5_max0_count", cnt_of(3), 0);
        end

        // 6: async reset mid-run with a live count and a set done flag
        enableCounter = '0;
        clear = '1;
        step();
        clear = '0;
        set_chan(0, 0, 20);
        set_chan(1, 1, 0);
        enableCounter = 4'b0011;
        repeat (6) step();
        check("t6_pre_count", cnt_of(0), 6);
        check("t6_pre_done", int'(done[1]), 1);
        mid_reset();
        enableCounter = 4'b0001;
        step();
        check("t6_post_count", cnt_of(0), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            enableCounter = 4'($urandom);
            clear = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 15) == 0) cascade = 4'($urandom);
            for (int i = 0; i < NCHAN; i++) begin
                if ($urandom_range(0, 31) == 0)
                    mode[2*i +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 31) == 0)
                    maxCount[i*W +: W] = ($urandom_range(0, 7) == 0) ?
                        W'($urandom_range(0, 1023)) : W'($urandom_range(0, 12));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
